head_sprite_fetch: RTL
======================

# head_sprite_fetch

Per-pixel sprite fetch stage for the player-2 snake head. It compares the VGA controller's current draw coordinates against the frame-latched sprite position and issues a read to the synchronous sprite ROM. It then pipelines the returned 4-bit colour index, with a transparency-qualified valid flag, to the downstream palette lookup and colour mux. It sits between the VGA controller / game-state logic and the head-sprite palette.

## Interface

Parameters:
- SPRITE_W, 32, sprite width in pixels; power of two.
- SPRITE_H, 32, sprite height in pixels; power of two.
- COORD_W, 10, width of all screen coordinates.
- ADDR_W, 10, ROM address width; equals log2(SPRITE_W*SPRITE_H).
- TRANSPARENT_IDX, 4'h2, palette index treated as transparent (magenta key).

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- sprite_en  in  1  head visible this frame; sampled on frame_start.
- pos_x  in  COORD_W  sprite top-left X; sampled on frame_start.
- pos_y  in  COORD_W  sprite top-left Y; sampled on frame_start.
- pixel_en  in  1  draw_x/draw_y hold a visible pixel this cycle.
- draw_x  in  COORD_W  current pixel X.
- draw_y  in  COORD_W  current pixel Y.
- rom_addr  out  ADDR_W  registered address to the sprite ROM.
- rom_data  in  4  ROM output; valid one cycle after rom_addr.
- pix_index  out  4  palette index for the downstream palette.
- pix_valid  out  1  sprite covers this pixel and the pixel is opaque.

## Operation

- Position latch:
  - On frame_start, pos_x, pos_y and sprite_en are captured into lat_x, lat_y and lat_en.
  - Between pulses, input changes are ignored, so there is no tearing mid-frame.
- Hit test (stage 1):
  - dx = draw_x − lat_x and dy = draw_y − lat_y, computed at COORD_W+1 bits.
  - hit = lat_en & pixel_en & dx ≥ 0 & dx < SPRITE_W & dy ≥ 0 & dy < SPRITE_H.
  - A negative difference (MSB set) is a miss. A sprite partially off the right or bottom edge is clipped, not wrapped.
- Address: rom_addr = {dy[log2 H−1:0], dx[log2 W−1:0]}, which is row-major dy*SPRITE_W + dx.
  - Registered every cycle.
  - On a miss, rom_addr is still updated from the low bits; its value is don't-care.
- Pipeline:
  - stage1 registers rom_addr and hit1.
  - stage2 delays the hit to hit2, aligned with rom_data.
  - stage3 registers pix_index = rom_data and pix_valid = hit2 & (rom_data ≠ TRANSPARENT_IDX).
- The pipeline advances every clock. There is no stall; pixel_en only qualifies the valid bit.
- There is no FSM beyond the latch and the pipeline. lat_en = 0 forces pix_valid = 0 for the whole frame.

## Timing

- Reset (Reset_n low, async):
  - lat_x = lat_y = 0, lat_en = 0.
  - rom_addr = 0, hit1 = hit2 = 0.
  - pix_index = 0, pix_valid = 0.
- Reset release: pix_valid stays 0 until the first frame_start with sprite_en = 1 has been latched.
- Latency: coordinates presented in cycle t appear on pix_index/pix_valid in cycle t+3.
  - rom_addr changes at t+1.
  - rom_data is valid at t+2.
- frame_start coinciding with pixel_en = 1:
  - The pixel in that cycle uses the old latched values.
  - New values apply from cycle t+1.
- Reset asserted mid-frame clears all pipeline stages immediately. No stale pix_valid emerges after release.
- Boundaries:
  - dx = SPRITE_W−1 is a hit; dx = SPRITE_W is a miss.
  - draw_x < lat_x is a miss.
  - lat_x near the coordinate maximum must not alias to a hit via wrap, which is why the (COORD_W+1)-bit subtract is required.

## Test plan

- Reset, then frame_start with pos = (100,50) and sprite_en = 1. Drive draw = (100,50) and rom_data = 4'h1 at t+2 -> rom_addr = 0 at t+1; pix_index = 1 and pix_valid = 1 at t+3.
- draw = (131,81) with pos (100,50) -> rom_addr = 1023, pix_valid = 1. draw = (132,50) -> pix_valid = 0. draw = (99,50) -> pix_valid = 0.
- Hit with rom_data = 4'h2 -> pix_index = 2, pix_valid = 0 (transparent).
- Change pos_x to 200 without frame_start; draw = (100,50) -> still a hit. After frame_start, same draw -> miss.
- frame_start with sprite_en = 0 and draw inside the box -> pix_valid = 0 for the whole frame. Before any frame_start after reset -> pix_valid = 0.
- Assert Reset_n = 0 while hits are in flight -> pix_valid and pix_index go to 0 immediately. After release, there is no valid output until a new latch plus 3 cycles.

Source files
------------

// File: rtl/head_sprite_fetch.sv
// Player-2 head sprite fetch: frame-latched position, hit test,
// ROM addressing and a three-stage colour-index pipeline.
module head_sprite_fetch #(
  parameter int             SPRITE_W        = 32,
  parameter int             SPRITE_H        = 32,
  parameter int             COORD_W         = 10,
  parameter int             ADDR_W          = 10,
  parameter logic [3:0]     TRANSPARENT_IDX = 4'h2
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic               sprite_en,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               pixel_en,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [3:0]         rom_data,
  output logic [3:0]         pix_index,
  output logic               pix_valid
);

  localparam int XB = $clog2(SPRITE_W);
  localparam int YB = $clog2(SPRITE_H);
  localparam logic [COORD_W:0] W_LIM = (COORD_W+1)'(SPRITE_W);
  localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(SPRITE_H);

  logic [COORD_W-1:0] lat_x;
  logic [COORD_W-1:0] lat_y;
  logic               lat_en;
  logic [COORD_W:0]   dx;
  logic [COORD_W:0]   dy;
  logic               hit;
  logic               hit1;
  logic               hit2;

  // Extra bit keeps a position near the coordinate max from wrapping.
  assign dx = {1'b0, draw_x} - {1'b0, lat_x};
  assign dy = {1'b0, draw_y} - {1'b0, lat_y};

  assign hit = lat_en & pixel_en
             & ~dx[COORD_W] & (dx < W_LIM)
             & ~dy[COORD_W] & (dy < H_LIM);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lat_x  <= '0;
      lat_y  <= '0;
      lat_en <= 1'b0;
    end else if (frame_start) begin
      lat_x  <= pos_x;
      lat_y  <= pos_y;
      lat_en <= sprite_en;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      hit1      <= 1'b0;
      hit2      <= 1'b0;
      pix_index <= 4'h0;
      pix_valid <= 1'b0;
    end else begin
      rom_addr  <= ADDR_W'({dy[YB-1:0], dx[XB-1:0]});
      hit1      <= hit;
      hit2      <= hit1;
      pix_index <= rom_data;
      pix_valid <= hit2 & (rom_data != TRANSPARENT_IDX);
    end
  end

endmodule
